// File: rtl/imem_arbiter_if.sv
// Bundle of signals between the instruction-memory arbiter, its two
// requesters (fetch and loader/debug) and the single-port instruction memory.
interface imem_arbiter_if #(
   parameter int ADDR_W     = 32,
   parameter int DEPTH_LOG2 = 10
);
   // fetch requester
   logic                  f_req;
   logic [ADDR_W-1:0]     f_addr;
   logic                  f_flush;
   logic                  f_gnt;
   logic                  f_rvalid;
   logic [31:0]           f_rdata;
   // loader / debug requester
   logic                  l_req;
   logic                  l_we;
   logic [ADDR_W-1:0]     l_addr;
   logic [31:0]           l_wdata;
   logic                  l_gnt;
   logic                  l_rvalid;
   logic [31:0]           l_rdata;
   logic                  l_err;
   // memory port
   logic                  m_en;
   logic                  m_we;
   logic [DEPTH_LOG2-1:0] m_addr;
   logic [31:0]           m_wdata;
   logic [31:0]           m_rdata;

   // arbiter side
   modport slave (
      input  f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, m_rdata,
      output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, l_err,
             m_en, m_we, m_addr, m_wdata
   );

   // requesters plus memory side
   modport master (
      output f_req, f_addr, f_flush, l_req, l_we, l_addr, l_wdata, m_rdata,
      input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, l_err,
             m_en, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: one access per cycle shared between the
// fetch stage and the loader/debug port. Loader normally wins, but fetch is
// forced through after STARVE_MAX consecutive denied cycles. Reads are tracked
// through a MEM_LAT-deep {valid, owner} pipeline so read data returns to the
// requester that issued it; f_flush kills in-flight fetch reads.
module imem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DEPTH_LOG2 = 10,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic           clk,
   input  logic           rst,
   imem_arbiter_if.slave  bus
);

   localparam int          LAST       = MEM_LAT - 1;
   localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

   logic [3:0]         starve_cnt;
   logic               f_win;
   logic               l_win;
   logic               l_mis;
   logic               rd_go;
   logic [MEM_LAT-1:0] vld_p;
   logic [MEM_LAT-1:0] own_f_p;
   logic               rsp_vld;
   logic [31:0]        f_rdata_hold;
   logic [31:0]        l_rdata_hold;
   logic               unused_addr;

   // Address bits outside the word index are intentionally ignored (fetch
   // wraps modulo memory size); loader low bits only feed the alignment check.
   assign unused_addr = ^{bus.f_addr[1:0],
                          bus.f_addr[ADDR_W-1:DEPTH_LOG2+2],
                          bus.l_addr[ADDR_W-1:DEPTH_LOG2+2]};

   // Grant decision: loader preferred unless fetch has hit its starvation limit.
   always_comb begin
      f_win = 1'b0;
      l_win = 1'b0;
      l_mis = 1'b0;
      if (!rst) begin
         if (bus.f_req && (!bus.l_req || starve_cnt == STARVE_LIM)) begin
            f_win = 1'b1;
         end else if (bus.l_req) begin
            l_win = 1'b1;
         end
         l_mis = l_win && (bus.l_addr[1:0] != 2'b00);
      end
   end

   // Memory command for the granted access; a misaligned loader access is
   // acknowledged but never reaches the memory.
   always_comb begin
      bus.m_en    = f_win || (l_win && !l_mis);
      bus.m_we    = l_win && !l_mis && bus.l_we;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      if (f_win) begin
         bus.m_addr = bus.f_addr[DEPTH_LOG2+1:2];
      end else if (l_win && !l_mis) begin
         bus.m_addr = bus.l_addr[DEPTH_LOG2+1:2];
         if (bus.l_we) begin
            bus.m_wdata = bus.l_wdata;
         end
      end
   end

   assign rd_go     = bus.m_en && !bus.m_we;
   assign bus.f_gnt = f_win;
   assign bus.l_gnt = l_win;
   assign bus.l_err = l_mis;

   // Consecutive-denial counter for fetch, saturating at the limit.
   always_ff @(posedge clk) begin
      if (rst || !bus.f_req || f_win) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Response valid pipeline p0..pLAST; flush drops fetch-owned entries as they move.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= rd_go;
         for (int i = 1; i < MEM_LAT; i++) begin
            vld_p[i] <= vld_p[i-1] && !(bus.f_flush && own_f_p[i-1]);
         end
      end
   end

   // Owner tag travels alongside each valid bit (1 = fetch issued the read).
   always_ff @(posedge clk) begin
      own_f_p[0] <= f_win;
      for (int i = 1; i < MEM_LAT; i++) begin
         own_f_p[i] <= own_f_p[i-1];
      end
   end

   // Final stage routes memory data to its owner; flush also kills the final stage.
   always_comb begin
      rsp_vld      = vld_p[LAST] && !rst;
      bus.f_rvalid = rsp_vld && own_f_p[LAST] && !bus.f_flush;
      bus.l_rvalid = rsp_vld && !own_f_p[LAST];
      bus.f_rdata  = rst ? 32'd0 : (bus.f_rvalid ? bus.m_rdata : f_rdata_hold);
      bus.l_rdata  = rst ? 32'd0 : (bus.l_rvalid ? bus.m_rdata : l_rdata_hold);
   end

   // Each requester's read data holds its last returned word between responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_rdata_hold <= '0;
         l_rdata_hold <= '0;
      end else begin
         if (bus.f_rvalid) begin
            f_rdata_hold <= bus.m_rdata;
         end
         if (bus.l_rvalid) begin
            l_rdata_hold <= bus.m_rdata;
         end
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: three instances (MEM_LAT = 1, 2, 3) share the same
// directed stimulus, each with its own memory and a queue-based reference model
// compared on every cycle, plus hand-computed literal expectations.
module tb_imem_arbiter;

   localparam int ADDR_W     = 32;
   localparam int DEPTH_LOG2 = 10;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
   localparam int STARVE_MAX = 4;
   localparam int NLANE      = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, f_flush, l_req, l_we;
   logic [31:0] f_addr, l_addr, l_wdata;

   logic        f_gnt_a [NLANE];
   logic        l_gnt_a [NLANE];
   logic        l_err_a [NLANE];
   logic        m_en_a [NLANE];
   logic        f_rvalid_a [NLANE];
   logic        l_rvalid_a [NLANE];
   logic [31:0] f_rdata_a [NLANE];
   logic [31:0] l_rdata_a [NLANE];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          due;
      bit          own_f;
      logic [31:0] data;
   } rsp_t;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int unsigned w);
      return 32'hA500_0000 | (w & 32'h0000_FFFF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NLANE; g++) begin : lane
      localparam int LAT = g + 1;

      imem_arbiter_if #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

      imem_arbiter #(
         .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2),
         .MEM_LAT(LAT), .STARVE_MAX(STARVE_MAX)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );

      assign bus.f_req   = f_req;
      assign bus.f_addr  = f_addr;
      assign bus.f_flush = f_flush;
      assign bus.l_req   = l_req;
      assign bus.l_we    = l_we;
      assign bus.l_addr  = l_addr;
      assign bus.l_wdata = l_wdata;

      assign f_gnt_a[g]    = bus.f_gnt;
      assign l_gnt_a[g]    = bus.l_gnt;
      assign l_err_a[g]    = bus.l_err;
      assign m_en_a[g]     = bus.m_en;
      assign f_rvalid_a[g] = bus.f_rvalid;
      assign l_rvalid_a[g] = bus.l_rvalid;
      assign f_rdata_a[g]  = bus.f_rdata;
      assign l_rdata_a[g]  = bus.l_rdata;

      // memory: writes land at the grant edge, reads emerge LAT cycles later
      logic [31:0] mem [DEPTH];
      bit          mem_wr [DEPTH];
      logic [31:0] rd_pipe [LAT];

      always @(posedge clk) begin
         if (bus.m_en && bus.m_we) begin
            mem[bus.m_addr]    <= bus.m_wdata;
            mem_wr[bus.m_addr] <= 1'b1;
         end
         rd_pipe[0] <= mem_wr[bus.m_addr] ? mem[bus.m_addr] : init_word(32'(bus.m_addr));
         for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end

      assign bus.m_rdata = rd_pipe[LAT-1];

      // reference model and per-cycle compare
      rsp_t        q[$];
      logic [31:0] ref_mem [DEPTH];
      bit          ref_wr [DEPTH];
      int          starve = 0;
      logic [31:0] e_frd  = 0;
      logic [31:0] e_lrd  = 0;

      always @(negedge clk) begin : model_cmp
         logic        e_fg, e_lg, e_err, e_men, e_mwe, e_frv, e_lrv;
         logic [31:0] e_maddr, e_mwd, rdv;
         int          wa;
         e_fg = 0; e_lg = 0; e_err = 0; e_men = 0; e_mwe = 0; e_frv = 0; e_lrv = 0;
         e_maddr = 0; e_mwd = 0; wa = 0; rdv = 0;
         if (rst) begin
            q.delete();
            starve = 0;
            e_frd  = 0;
            e_lrd  = 0;
         end else begin
            if (f_flush)
               for (int i = q.size() - 1; i >= 0; i--)
                  if (q[i].own_f) q.delete(i);
            for (int i = q.size() - 1; i >= 0; i--) begin
               if (q[i].due == cyc) begin
                  if (q[i].own_f) begin e_frv = 1; e_frd = q[i].data; end
                  else            begin e_lrv = 1; e_lrd = q[i].data; end
                  q.delete(i);
               end
            end
            if (f_req && (!l_req || starve == STARVE_MAX)) e_fg = 1;
            else if (l_req)                                e_lg = 1;
            e_err = e_lg && (l_addr % 4 != 0);
            wa    = e_fg ? int'((f_addr / 4) % DEPTH) : int'((l_addr / 4) % DEPTH);
            if (e_fg || (e_lg && !e_err)) begin
               e_men   = 1;
               e_maddr = wa;
            end
            if (e_lg && !e_err && l_we) begin
               e_mwe       = 1;
               e_mwd       = l_wdata;
               ref_mem[wa] = l_wdata;
               ref_wr[wa]  = 1;
            end else if (e_men) begin
               rdv = ref_wr[wa] ? ref_mem[wa] : init_word(wa);
               q.push_back('{cyc + LAT, e_fg, rdv});
            end
            if (!f_req || e_fg)          starve = 0;
            else if (starve < STARVE_MAX) starve = starve + 1;
         end
         chk($sformatf("L%0d f_gnt", g),    32'(bus.f_gnt),    32'(e_fg));
         chk($sformatf("L%0d l_gnt", g),    32'(bus.l_gnt),    32'(e_lg));
         chk($sformatf("L%0d l_err", g),    32'(bus.l_err),    32'(e_err));
         chk($sformatf("L%0d m_en", g),     32'(bus.m_en),     32'(e_men));
         chk($sformatf("L%0d m_we", g),     32'(bus.m_we),     32'(e_mwe));
         if (rst || e_men) chk($sformatf("L%0d m_addr", g), 32'(bus.m_addr), e_maddr);
         if (rst || e_mwe) chk($sformatf("L%0d m_wdata", g), bus.m_wdata, e_mwd);
         chk($sformatf("L%0d f_rvalid", g), 32'(bus.f_rvalid), 32'(e_frv));
         chk($sformatf("L%0d f_rdata", g),  bus.f_rdata,       e_frd);
         chk($sformatf("L%0d l_rvalid", g), 32'(bus.l_rvalid), 32'(e_lrv));
         chk($sformatf("L%0d l_rdata", g),  bus.l_rdata,       e_lrd);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      f_req = 0; l_req = 0; f_flush = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin : stim
      logic [9:0] pat_f;
      pat_f = 10'b10_0001_0000;

      // reset held with both requests active
      rst = 1; f_req = 1; f_addr = 32'h20; f_flush = 0;
      l_req = 1; l_we = 0; l_addr = 32'h100; l_wdata = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst f_gnt", 32'(f_gnt_a[0]), 0);
         chk("rst l_gnt", 32'(l_gnt_a[0]), 0);
         chk("rst m_en",  32'(m_en_a[0]),  0);
         chk("rst f_rdata", f_rdata_a[2], 0);
         tick();
      end

      // release: loader wins first, then 4:1 loader/fetch pattern
      rst = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("starve f_gnt", 32'(f_gnt_a[0]), 32'(pat_f[i]));
         chk("starve l_gnt", 32'(l_gnt_a[0]), 32'(!pat_f[i]));
         tick();
      end
      idle(4);

      // loader write then fetch read of the same word
      l_req = 1; l_we = 1; l_addr = 32'h10; l_wdata = 32'h0050_0093;
      @(negedge clk);
      chk("wr l_gnt", 32'(l_gnt_a[0]), 1);
      tick();
      l_req = 0; f_req = 1; f_addr = 32'h10;
      @(negedge clk);
      chk("rd f_gnt", 32'(f_gnt_a[0]), 1);
      tick();
      f_addr = 32'h0000_1013;           // wraps onto the same word, low bits ignored
      @(negedge clk);
      chk("rd f_rvalid L0", 32'(f_rvalid_a[0]), 1);
      chk("rd f_rdata L0",  f_rdata_a[0], 32'h0050_0093);
      chk("rd l_rvalid L0", 32'(l_rvalid_a[0]), 0);
      chk("rd f_rvalid L1", 32'(f_rvalid_a[1]), 0);
      tick();
      f_req = 0;
      @(negedge clk);
      chk("wrap f_rvalid L0", 32'(f_rvalid_a[0]), 1);
      chk("wrap f_rdata L0",  f_rdata_a[0], 32'h0050_0093);
      tick();
      idle(4);

      // back-to-back fetches, flush one cycle after the third grant
      f_req = 1; f_addr = 32'h0;
      tick();
      f_addr = 32'h4;
      @(negedge clk);
      chk("fl L0 f_rdata 0x0", f_rdata_a[0], 32'hA500_0000);
      tick();
      f_addr = 32'h8;
      tick();
      f_flush = 1; f_addr = 32'h40;
      @(negedge clk);
      chk("fl f_gnt 0x40", 32'(f_gnt_a[0]), 1);
      chk("fl L0 f_rvalid", 32'(f_rvalid_a[0]), 0);
      chk("fl L2 f_rvalid", 32'(f_rvalid_a[2]), 0);
      tick();
      f_flush = 0; f_req = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("fl L2 killed f_rvalid", 32'(f_rvalid_a[2]), 0);
         tick();
      end
      @(negedge clk);
      chk("fl L2 f_rvalid 0x40", 32'(f_rvalid_a[2]), 1);
      chk("fl L2 f_rdata 0x40",  f_rdata_a[2], 32'hA500_0010);
      tick();
      idle(3);

      // flush leaves loader reads alone
      l_req = 1; l_we = 0; l_addr = 32'h44;
      tick();
      l_req = 0; f_flush = 1;
      @(negedge clk);
      chk("fl loader l_rvalid L0", 32'(l_rvalid_a[0]), 1);
      chk("fl loader l_rdata L0",  l_rdata_a[0], 32'hA500_0011);
      tick();
      f_flush = 0;
      idle(4);

      // misaligned loader read and write are acknowledged but dropped
      l_req = 1; l_we = 0; l_addr = 32'h13;
      @(negedge clk);
      chk("mis l_gnt", 32'(l_gnt_a[0]), 1);
      chk("mis l_err", 32'(l_err_a[0]), 1);
      chk("mis m_en",  32'(m_en_a[0]),  0);
      tick();
      l_we = 1; l_addr = 32'h22; l_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("mis wr l_err", 32'(l_err_a[0]), 1);
      chk("mis l_rvalid L0", 32'(l_rvalid_a[0]), 0);
      tick();
      l_we = 0; l_addr = 32'h20;
      tick();
      l_req = 0;
      @(negedge clk);
      chk("mis after l_rvalid L0", 32'(l_rvalid_a[0]), 1);
      chk("mis after l_rdata L0",  l_rdata_a[0], 32'hA500_0008);
      tick();
      idle(4);

      // reset while a loader read is in flight
      l_req = 1; l_we = 0; l_addr = 32'h18;
      @(negedge clk);
      chk("rstf l_gnt", 32'(l_gnt_a[0]), 1);
      tick();
      l_req = 0; rst = 1;
      @(negedge clk);
      chk("rstf L0 l_rvalid", 32'(l_rvalid_a[0]), 0);
      tick();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rstf L1 l_rvalid", 32'(l_rvalid_a[1]), 0);
         chk("rstf L2 l_rvalid", 32'(l_rvalid_a[2]), 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares the single instruction-memory port between the pipeline fetch stage and the program loader/debug port. Arbitrates one access per cycle and tracks in-flight reads through a MEM_LAT-deep response pipeline. Returns read data to the requester that issued the read. Fetch stalls whenever its request is not granted; a fetch flush discards stale in-flight fetch responses after a branch redirect.

## Interface
- ADDR_W, 32, byte-address width of both requester ports
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words
- MEM_LAT, 1, memory read latency in cycles from m_en to m_rdata valid; legal 1..4
- STARVE_MAX, 4, maximum consecutive cycles fetch may be denied while loader wins; legal 1..15

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch read request, held until f_gnt
- f_addr  in  ADDR_W  fetch byte address
- f_flush  in  1  kill all in-flight fetch responses
- f_gnt  out  1  fetch request accepted this cycle (0 = stall fetch)
- f_rvalid  out  1  f_rdata valid
- f_rdata  out  32  fetched instruction word
- l_req  in  1  loader request, held until l_gnt
- l_we  in  1  1 = write, 0 = read
- l_addr  in  ADDR_W  loader byte address
- l_wdata  in  32  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  l_rdata valid
- l_rdata  out  32  loader read data
- l_err  out  1  one-cycle pulse, misaligned loader access rejected
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  DEPTH_LOG2  word address = selected addr[DEPTH_LOG2+1:2]
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid MEM_LAT cycles after m_en with m_we=0

## Operation
- Grant is combinational from the current cycle's requests and registered state. At most one of f_gnt and l_gnt is high. m_en/m_we/m_addr/m_wdata are driven in the grant cycle.
- Arbitration:
  - Only one requester active: grant it.
  - Both active: grant the loader unless starve_cnt == STARVE_MAX, in which case grant fetch.
- starve_cnt (registered, 4 bits):
  - Cleared when f_req is low or f_gnt is high.
  - Otherwise increments, saturating at STARVE_MAX.
- Fetch address: bits [1:0] are ignored (word-aligned by construction). Bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo the memory size.
- Loader misalignment: if l_addr[1:0] != 0, the request is still granted (l_gnt=1), but m_en stays 0, l_err pulses in the grant cycle, and no response follows.
- Response pipeline: MEM_LAT stages of {valid, owner}. A stage is loaded on every granted read with m_en=1; writes load valid=0. At the last stage, m_rdata is routed to the owner's rdata and the owner's rvalid pulses for one cycle. The non-owner's rdata holds its previous value.
- f_flush: clears valid on every stage whose owner is fetch, including the final stage, so f_rvalid is 0 in the flush cycle. A fetch granted in the same cycle as f_flush is not killed. Loader entries are unaffected.
- Reset: while rst=1, all outputs are 0, all pipeline stages are invalid, starve_cnt=0, and f_rdata/l_rdata are 0. Reads in flight when rst asserts never produce rvalid.

## Timing
- Throughput: one access per cycle, with no bubble between back-to-back grants.
- Read latency: rvalid rises exactly MEM_LAT cycles after the rising edge that ends the grant cycle (grant in cycle N, rvalid in cycle N+MEM_LAT).
- Writes complete at the grant-cycle edge. A read of the same word granted in the next cycle returns the new data.
- Fetch worst-case wait with continuous loader traffic: STARVE_MAX cycles, then one fetch grant, after which the counter restarts.
- Requester contract: address, l_we and l_wdata are stable while req is high and gnt is low. Dropping req before grant is legal and cancels the request.

## Test plan
- Reset: hold rst=1 for 3 cycles with both requests high -> all outputs 0; after release, starve_cnt=0 and the first grant goes to the loader.
- Loader write then fetch read (MEM_LAT=1): loader writes 0x00500093 to byte address 0x10, then fetch reads 0x10 -> f_rvalid in cycle N+1 with f_rdata=0x00500093, l_rvalid stays 0.
- Starvation (STARVE_MAX=4): l_req and f_req both held high continuously -> l_gnt for 4 cycles, f_gnt on the 5th, repeating the 4:1 pattern.
- Flush: fetch reads 0x0, 0x4, 0x8 back-to-back with MEM_LAT=3, f_flush asserted in the cycle after the 0x8 grant, fetch 0x40 granted the same cycle -> only the 0x40 response is returned.
- Misaligned loader read at 0x13 -> l_gnt=1, l_err pulse, m_en=0, no l_rvalid.
- Reset mid-flight: grant a loader read with MEM_LAT=2, assert rst the next cycle -> l_rvalid never asserts.
